// File: rtl/aesl_deadlock_axis_monitor_n_if.sv
// Block-flag inputs and deadlock report outputs for the AXIS deadlock monitor.
// master drives the flags and reads the report; slave is the monitor.
interface aesl_deadlock_axis_monitor_n_if #(
  parameter int NUM_AXIS = 4,
  parameter int NUM_INST = 1,
  parameter int CNT_W    = 16
);
  localparam int IDX_W = $clog2(NUM_AXIS + 1);

  logic [NUM_AXIS-1:0]   axis_block_sigs;
  logic [NUM_AXIS-1:0]   inst_idle_sigs;
  logic [NUM_INST-1:0]   inst_block_sigs;
  logic                  clear;
  logic [4*NUM_AXIS-1:0] axis_block_info;
  logic                  block;
  logic [IDX_W-1:0]      first_idx;
  logic [CNT_W-1:0]      deadlock_cycles;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  axis_block_info, block, first_idx, deadlock_cycles
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output axis_block_info, block, first_idx, deadlock_cycles
  );
endinterface

// File: rtl/aesl_deadlock_axis_monitor_n.sv
// Dataflow deadlock monitor: block flags must persist HOLD_CYCLES to declare DEADLOCK.
// Latency: block rises HOLD_CYCLES+1 cycles after a raw flag rises; drops 2 cycles after it falls.
// Backpressure: none, observe-only; AESL_DEADLOCK_STICKY_EN makes DEADLOCK exit only on clear.
module aesl_deadlock_axis_monitor_n #(
  parameter int NUM_AXIS    = 4,
  parameter int NUM_INST    = 1,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input logic                           clock,
  input logic                           reset,
  aesl_deadlock_axis_monitor_n_if.slave mon
);
  localparam int NCH   = NUM_AXIS + 1;
  localparam int IDX_W = $clog2(NUM_AXIS + 1);
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_V = HC_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    MON      = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } state_t;

  state_t                 state;
  logic                   block_q;
  logic [NUM_AXIS-1:0]    info_mask;
  logic [IDX_W-1:0]       first_idx_q;
  logic [CNT_W-1:0]       dl_cnt;
  logic [NCH-1:0]         raw;
  logic [NCH-1:0]         qual;
  logic [IDX_W-1:0]       first_q;
  logic [4*NUM_AXIS-1:0]  info_w;
  logic                   any_raw;
  logic                   any_qual;
  logic                   dl_sat;

  // Top channel is the OR of all sub-instance block flags.
  assign raw      = {|mon.inst_block_sigs, mon.axis_block_sigs & ~mon.inst_idle_sigs};
  assign any_raw  = |raw;
  assign any_qual = |qual;
  assign dl_sat   = &dl_cnt;

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    logic [HC_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (mon.clear || !raw[k]) begin
        cnt <= '0;
      end else if (cnt != HOLD_V) begin
        cnt <= cnt + HC_W'(1);
      end
    end

    assign qual[k] = (cnt == HOLD_V);
  end

  always_comb begin
    first_q = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (qual[k]) first_q = IDX_W'(k);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= MON;
      block_q     <= 1'b0;
      info_mask   <= '0;
      first_idx_q <= '0;
      dl_cnt      <= '0;
    end else if (mon.clear) begin
      state     <= MON;
      block_q   <= 1'b0;
      info_mask <= '0;
    end else begin
      case (state)
        MON: begin
          if (any_raw) state <= SUSPECT;
        end
        SUSPECT: begin
          if (any_qual) begin
            state       <= DEADLOCK;
            block_q     <= 1'b1;
            info_mask   <= qual[NUM_AXIS-1:0];
            first_idx_q <= first_q;
            dl_cnt      <= CNT_W'(1);
          end else if (!any_raw) begin
            state <= MON;
          end
        end
        DEADLOCK: begin
`ifdef AESL_DEADLOCK_STICKY_EN
          info_mask <= info_mask | qual[NUM_AXIS-1:0];
          if (!dl_sat) dl_cnt <= dl_cnt + CNT_W'(1);
`else
          if (!any_qual) begin
            state     <= MON;
            block_q   <= 1'b0;
            info_mask <= '0;
          end else begin
            info_mask <= info_mask | qual[NUM_AXIS-1:0];
            if (!dl_sat) dl_cnt <= dl_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state     <= MON;
          block_q   <= 1'b0;
          info_mask <= '0;
        end
      endcase
    end
  end

  // Each flagged channel reports its nibble with bit (i%4) low.
  always_comb begin
    info_w = '0;
    for (int i = 0; i < NUM_AXIS; i++) begin
      if (block_q && info_mask[i]) info_w[4*i +: 4] = ~(4'h1 << (i % 4));
    end
  end

  assign mon.axis_block_info = info_w;
  assign mon.block           = block_q;
  assign mon.first_idx       = first_idx_q;
  assign mon.deadlock_cycles = dl_cnt;
endmodule

// File: doc/aesl_deadlock_axis_monitor_n.md
Name: aesl_deadlock_axis_monitor_n

Overview:
- Parametrised co-simulation deadlock monitor for HLS dataflow instances.
- Watches NUM_AXIS stream-channel block flags plus NUM_INST sub-instance block flags.
- Qualifies each block flag with a persistence threshold, so a flag must stay high for HOLD_CYCLES consecutive cycles to count.
- Runs a small FSM, reports a per-channel one-hot-low info word, the first offending channel, and a deadlock duration counter to the testbench deadlock reporter.

Parameters:
- NUM_AXIS, 4: number of monitored stream channels.
- NUM_INST, 1: number of sub-instance block inputs.
- HOLD_CYCLES, 4: consecutive raw-block cycles required to qualify a channel; must be >= 1.
- CNT_W, 16: width of deadlock_cycles.

Ports:
- clock  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- axis_block_sigs  in  NUM_AXIS  raw per-channel block flags.
- inst_idle_sigs  in  NUM_AXIS  per-channel owning-instance idle; masks the matching block flag.
- inst_block_sigs  in  NUM_INST  sub-instance block flags.
- clear  in  1  synchronous clear of detection state.
- axis_block_info  out  4*NUM_AXIS  per-channel nibble report.
- block  out  1  deadlock declared.
- first_idx  out  $clog2(NUM_AXIS+1)  lowest qualified index on deadlock entry; the value NUM_AXIS means instance channel.
- deadlock_cycles  out  CNT_W  cycles spent in DEADLOCK, saturating.

Behaviour:
- Raw channel terms:
  - raw[i] = axis_block_sigs[i] & ~inst_idle_sigs[i] for i < NUM_AXIS.
  - raw[NUM_AXIS] = OR of inst_block_sigs.
- Per-channel counter cnt[k]:
  - Clears to 0 when raw[k]=0.
  - Otherwise increments, saturating at HOLD_CYCLES.
  - qual[k] = (cnt[k] == HOLD_CYCLES).
- FSM states MON, SUSPECT, DEADLOCK; reset state MON.
  - MON: any raw -> SUSPECT.
  - SUSPECT: any qual -> DEADLOCK; else if no raw -> MON; else stay.
  - DEADLOCK: no qual -> MON (non-sticky); else stay.
- Latency: with raw[k] continuously high from cycle t, block=1 from cycle t+HOLD_CYCLES+1.
- Deassertion (non-sticky): block drops 2 cycles after the last raw term falls.
- block = (state == DEADLOCK), driven from a register.
- info_mask register, width NUM_AXIS:
  - Loaded with qual[NUM_AXIS-1:0] on the SUSPECT->DEADLOCK transition.
  - ORed with qual every cycle while in DEADLOCK.
  - Cleared on entry to MON.
- axis_block_info nibble i = ~(4'h1 << (i%4)) if info_mask[i], else 4'h0. Output is all zero when block=0.
- first_idx: captured on DEADLOCK entry as the lowest k with qual[k]; held until the next entry. Reset value 0.
- deadlock_cycles: loaded to 1 on DEADLOCK entry, +1 per cycle in DEADLOCK, saturates at all-ones, holds its value after exit. Reset value 0.
- Simultaneous clear and detection: clear wins; FSM -> MON, all cnt=0, info_mask=0 on the next edge.
- Reset mid-operation: all registers and outputs go to 0 / MON immediately, without waiting for a clock.
- Channels qualifying on the same cycle: first_idx takes the lowest index; all of them appear in axis_block_info.

Optional Feature:
- Macro: AESL_DEADLOCK_STICKY_EN.
- Defined: DEADLOCK exits only on clear. block, info_mask and first_idx latch after raw terms fall. deadlock_cycles keeps counting until clear.
- Undefined: non-sticky exit as described under Behaviour.

Test Plan:
- NUM_AXIS=4, HOLD_CYCLES=4; release reset, then drive axis_block_sigs=4'b0010 continuously from cycle 0 -> block=1 at cycle 5, axis_block_info=16'h00D0, first_idx=1, deadlock_cycles=1 at cycle 5.
- axis_block_sigs[2] high for 3 cycles then low -> block never asserts; FSM returns to MON; axis_block_info stays 16'h0000.
- axis_block_sigs=4'b0001 with inst_idle_sigs=4'b0001 for 20 cycles -> block=0 throughout.
- axis_block_sigs=4'b1010 rising on the same cycle -> first_idx=1, axis_block_info=16'h70D0.
- After the first scenario, drop axis_block_sigs to 0 at cycle 10 -> block=0 at cycle 12, deadlock_cycles holds 7. With AESL_DEADLOCK_STICKY_EN defined, block stays 1 until a clear pulse at cycle 20, then block=0 at cycle 21.
- Assert reset asynchronously mid-DEADLOCK -> block, axis_block_info, first_idx and deadlock_cycles read 0 before the next clock edge.
